// File: rtl/vua_ir_pkg.sv
// Shared types for the vua register-IR executor: opcodes, instruction field
// positions and FSM states.
package vua_ir_pkg;

    localparam int OP_LSB = 27;
    localparam int OP_W   = 5;
    localparam int RD_LSB = 23;
    localparam int RA_LSB = 19;
    localparam int RB_LSB = 15;
    localparam int IMM_W  = 12;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 5'd0,
        OP_LDI  = 5'd1,
        OP_ADD  = 5'd2,
        OP_SUB  = 5'd3,
        OP_AND  = 5'd4,
        OP_OR   = 5'd5,
        OP_XOR  = 5'd6,
        OP_EQ   = 5'd7,
        OP_LT   = 5'd8,
        OP_NEG  = 5'd9,
        OP_NOT  = 5'd10,
        OP_CJT  = 5'd11,
        OP_CJF  = 5'd12,
        OP_JMP  = 5'd13,
        OP_ST   = 5'd14,
        OP_HALT = 5'd15
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_EXEC       = 3'd2,
        ST_STORE_WAIT = 3'd3,
        ST_HALTED     = 3'd4,
        ST_FAULT      = 3'd5
    } state_e;

    function automatic op_e instr_op(input logic [31:0] instr);
        return op_e'(instr[OP_LSB +: OP_W]);
    endfunction

endpackage

// File: rtl/vua_ir_alu.sv
// Combinational datapath for the vua IR: computes the write-back value and
// decodes whether an opcode is legal, a branch, or writes its destination.
module vua_ir_alu
    import vua_ir_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              is_branch_o,
    output logic              is_legal_o,
    output logic              writes_rd_o
);

    always_comb begin
        result_o    = '0;
        is_branch_o = 1'b0;
        is_legal_o  = 1'b1;
        writes_rd_o = 1'b1;
        case (op_e'(op_i))
            // LDI arrives with the sign-extended immediate already on b_i
            OP_LDI:  result_o = b_i;
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_EQ:   result_o = DATA_W'(a_i == b_i);
            OP_LT:   result_o = DATA_W'($signed(a_i) < $signed(b_i));
            OP_NEG:  result_o = -a_i;
            OP_NOT:  result_o = DATA_W'(a_i == '0);
            OP_NOP, OP_ST, OP_HALT: writes_rd_o = 1'b0;
            OP_CJT, OP_CJF, OP_JMP: begin
                writes_rd_o = 1'b0;
                is_branch_o = 1'b1;
            end
            default: begin
                writes_rd_o = 1'b0;
                is_legal_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/vua_ir_exec.sv
// Executes vua register IR: fetches over a request/valid port, runs one
// instruction per EXEC cycle against a private register file, issues stores.
module vua_ir_exec
    import vua_ir_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int PC_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic              if_req,
    output logic [PC_W-1:0]   if_addr,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [DATA_W-1:0] st_addr,
    output logic [DATA_W-1:0] st_data,
    input  logic [REG_AW-1:0] dbg_idx,
    output logic [DATA_W-1:0] dbg_data,
    output logic [2:0]        dbg_state
);

    localparam int NREGS = 2**REG_AW;

    // Handshakes: a fetch completes in the cycle if_req & if_valid; a store
    // completes in the cycle st_valid & st_ready. Requests hold until then.
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] st_addr_q, st_addr_d;
    logic [DATA_W-1:0] st_data_q, st_data_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] regs_q [NREGS];

    op_e               op;
    logic [REG_AW-1:0] rd_idx, ra_idx, rb_idx;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] rd_val, ra_val, rb_val, alu_b, alu_res;
    logic              is_branch, is_legal, writes_rd, wr_en, taken;
    logic [PC_W-1:0]   pc_inc, br_tgt;
    logic              unused_instr_bits;

    assign op     = instr_op(instr_q);
    assign rd_idx = instr_q[RD_LSB +: REG_AW];
    assign ra_idx = instr_q[RA_LSB +: REG_AW];
    assign rb_idx = instr_q[RB_LSB +: REG_AW];
    assign imm    = instr_q[IMM_W-1:0];
    assign unused_instr_bits = ^instr_q[14:12];

    assign rd_val = regs_q[rd_idx];
    assign ra_val = regs_q[ra_idx];
    assign rb_val = regs_q[rb_idx];
    assign alu_b  = (op == OP_LDI) ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : rb_val;

    assign pc_inc = pc_q + PC_W'(1);
    assign br_tgt = PC_W'(imm);
    assign taken  = (op == OP_JMP) ||
                    (op == OP_CJT && ra_val != '0) ||
                    (op == OP_CJF && ra_val == '0);

    vua_ir_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i        (instr_q[OP_LSB +: OP_W]),
        .a_i         (ra_val),
        .b_i         (alu_b),
        .result_o    (alu_res),
        .is_branch_o (is_branch),
        .is_legal_o  (is_legal),
        .writes_rd_o (writes_rd)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        st_addr_d = st_addr_q;
        st_data_d = st_data_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED, ST_FAULT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                if (if_valid) begin
                    instr_d = if_instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                if (!is_legal) begin
                    state_d = ST_FAULT;
                    pc_d    = pc_q;
                end else if (op == OP_HALT) begin
                    state_d = ST_HALTED;
                    pc_d    = pc_q;
                    done_d  = 1'b1;
                end else if (op == OP_ST) begin
                    state_d   = ST_STORE_WAIT;
                    st_addr_d = rd_val;
                    st_data_d = ra_val;
                end else if (is_branch) begin
                    if (taken) pc_d = br_tgt;
                end else begin
                    wr_en = writes_rd;
                end
            end
            ST_STORE_WAIT: begin
                if (st_ready) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            st_addr_q <= '0;
            st_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[rd_idx] <= alu_res;
        end
    end

    // All handshake outputs decode from state so reset drops them at once
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_STORE_WAIT);
    assign done      = done_q;
    assign fault     = (state_q == ST_FAULT);
    assign if_req    = (state_q == ST_FETCH);
    assign if_addr   = pc_q;
    assign st_valid  = (state_q == ST_STORE_WAIT);
    assign st_addr   = st_addr_q;
    assign st_data   = st_data_q;
    assign dbg_data  = regs_q[dbg_idx];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vua_ir_exec.sv
// Directed bench for vua_ir_exec: a table of small programs with expected
// register results, plus hand-written store, overflow, fault, wrap and reset sequences.
module tb_vua_ir_exec;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam int PC_W   = 12;

    localparam int OP_LDI = 1,  OP_ADD = 2,  OP_SUB = 3,  OP_AND = 4,  OP_OR  = 5;
    localparam int OP_XOR = 6,  OP_EQ  = 7,  OP_LT  = 8,  OP_NEG = 9,  OP_NOT = 10;
    localparam int OP_CJT = 11, OP_CJF = 12, OP_JMP = 13, OP_ST  = 14, OP_HALT = 15;

    logic              clk = 1'b0;
    logic              rst_n, start, if_valid, st_ready;
    logic [31:0]       if_instr;
    logic [REG_AW-1:0] dbg_idx;
    logic              busy, done, fault, if_req, st_valid;
    logic [PC_W-1:0]   if_addr;
    logic [DATA_W-1:0] st_addr, st_data, dbg_data;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    vua_ir_exec #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .dbg_idx   (dbg_idx),
        .dbg_data  (dbg_data),
        .dbg_state (dbg_state)
    );

    logic [31:0] imem [4096];
    logic [63:0] exp_q [$];
    int total = 0, bad = 0;
    int fetch_lat = 1, lat_cnt = 0, fetch_cnt = 0;
    bit fetch_stall = 1'b0;
    int st_delay = 0, st_wait_cnt = 0, st_valid_cycles = 0, st_accepts = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [5:0][31:0] prog;
        logic [3:0]       ridx;
        logic [31:0]      exp;
        logic [7:0]       nf;
    } vec_t;
    vec_t vecs [24];
    int nv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int ra, input int rb, input int imm);
        logic [31:0] w;
        w = '0;
        w[31:27] = op[4:0];
        w[26:23] = rd[3:0];
        w[22:19] = ra[3:0];
        w[18:15] = rb[3:0];
        w[11:0]  = imm[11:0];
        return w;
    endfunction

    function automatic logic [31:0] ldi(input int rd, input int imm);
        return enc(OP_LDI, rd, 0, 0, imm);
    endfunction
    function automatic logic [31:0] r3(input int op, input int rd, input int ra, input int rb);
        return enc(op, rd, ra, rb, 0);
    endfunction
    function automatic logic [31:0] br(input int op, input int ra, input int tgt);
        return enc(op, 0, ra, 0, tgt);
    endfunction
    function automatic logic [31:0] hlt();
        return enc(OP_HALT, 0, 0, 0, 0);
    endfunction

    task automatic add_vec(input logic [31:0] p0, p1, p2, p3, p4, p5,
                           input int ridx, input logic [31:0] exp, input int nf);
        vec_t v;
        v.prog[0] = p0; v.prog[1] = p1; v.prog[2] = p2;
        v.prog[3] = p3; v.prog[4] = p4; v.prog[5] = p5;
        v.ridx = ridx[3:0];
        v.exp  = exp;
        v.nf   = nf[7:0];
        vecs[nv] = v;
        nv++;
    endtask

    // Instruction memory responder: answers a fetch after fetch_lat idle negedges
    initial begin
        if_valid = 1'b0;
        if_instr = '0;
        forever begin
            @(negedge clk);
            if_valid = 1'b0;
            if (rst_n && if_req && !fetch_stall) begin
                if (lat_cnt >= fetch_lat) begin
                    if_valid = 1'b1;
                    if_instr = imem[if_addr];
                    fetch_cnt++;
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Store sink: holds st_ready low for st_delay valid cycles, checks payload every cycle
    initial begin
        st_ready = 1'b0;
        forever begin
            @(negedge clk);
            st_ready = 1'b0;
            if (rst_n && st_valid) begin
                st_valid_cycles++;
                check("st_pending", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) begin
                    check("st_addr", st_addr, exp_q[0][63:32]);
                    check("st_data", st_data, exp_q[0][31:0]);
                end
                if (st_wait_cnt >= st_delay) begin
                    st_ready = 1'b1;
                    st_wait_cnt = 0;
                    st_accepts++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    st_wait_cnt++;
                end
            end else begin
                st_wait_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_imem();
        for (int i = 0; i < 4096; i++) imem[i] = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int budget);
        int n;
        n = 0;
        while (!(done || fault) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_end"}, 32'(done || fault), 32'd1);
    endtask

    task automatic read_reg(input int idx, output logic [31:0] val);
        dbg_idx = idx[REG_AW-1:0];
        #1;
        val = dbg_data;
    endtask

    task automatic run_prog(input string name, input int budget);
        fetch_cnt = 0;
        done_cnt  = 0;
        pulse_start();
        wait_end(name, budget);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        rst_n = 1'b0;
        start = 1'b0;
        dbg_idx = '0;

        add_vec(ldi(1, 5), ldi(2, -3), r3(OP_ADD, 3, 1, 2), hlt(), 0, 0, 3, 32'd2, 4);
        add_vec(ldi(1, 0), br(OP_CJF, 1, 4), ldi(5, 9), hlt(), hlt(), 0, 5, 32'd0, 3);
        add_vec(ldi(1, 1), br(OP_CJF, 1, 4), ldi(5, 9), hlt(), hlt(), 0, 5, 32'd9, 4);
        add_vec(ldi(1, 7), br(OP_CJT, 1, 3), ldi(6, 1), ldi(6, 2), hlt(), 0, 6, 32'd2, 4);
        add_vec(ldi(1, 0), br(OP_CJT, 1, 3), ldi(6, 1), hlt(), 0, 0, 6, 32'd1, 4);
        add_vec(ldi(1, 5), ldi(2, 7), r3(OP_SUB, 3, 1, 2), hlt(), 0, 0, 3, 32'hFFFF_FFFE, 4);
        add_vec(ldi(1, 'hF0), ldi(2, 'hFF), r3(OP_AND, 3, 1, 2), hlt(), 0, 0, 3, 32'h0000_00F0, 4);
        add_vec(ldi(1, 'hF0), ldi(2, 'h10F), r3(OP_OR, 3, 1, 2), hlt(), 0, 0, 3, 32'h0000_01FF, 4);
        add_vec(ldi(1, 'hF0), ldi(2, 'hFF), r3(OP_XOR, 3, 1, 2), hlt(), 0, 0, 3, 32'h0000_000F, 4);
        add_vec(ldi(1, -1), ldi(2, -1), r3(OP_EQ, 3, 1, 2), hlt(), 0, 0, 3, 32'd1, 4);
        add_vec(ldi(1, -1), ldi(2, -2), r3(OP_EQ, 3, 1, 2), hlt(), 0, 0, 3, 32'd0, 4);
        add_vec(ldi(1, 5), r3(OP_NEG, 2, 1, 0), hlt(), 0, 0, 0, 2, 32'hFFFF_FFFB, 3);
        add_vec(r3(OP_NOT, 2, 0, 0), hlt(), 0, 0, 0, 0, 2, 32'd1, 2);
        add_vec(ldi(1, 3), r3(OP_NOT, 1, 1, 0), hlt(), 0, 0, 0, 1, 32'd0, 3);
        add_vec(ldi(1, -1), ldi(2, 1), r3(OP_LT, 3, 1, 2), hlt(), 0, 0, 3, 32'd1, 4);
        add_vec(ldi(1, -1), ldi(2, 1), r3(OP_LT, 3, 2, 1), hlt(), 0, 0, 3, 32'd0, 4);
        add_vec(ldi(4, 5), br(OP_JMP, 0, 3), ldi(4, 9), hlt(), 0, 0, 4, 32'd5, 3);
        add_vec(ldi(1, 'h7FF), ldi(2, -2048), hlt(), 0, 0, 0, 2, 32'hFFFF_F800, 3);
        add_vec(ldi(7, 6), r3(OP_ADD, 7, 7, 7), hlt(), 0, 0, 0, 7, 32'd12, 3);

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_if_req", if_req, 0);
        check("rst_if_addr", 32'(if_addr), 0);
        check("rst_st_valid", st_valid, 0);
        check("rst_st_addr", st_addr, 0);
        check("rst_st_data", st_data, 0);
        check("rst_dbg_data", dbg_data, 0);
        check("rst_state", 32'(dbg_state), 0);

        for (int i = 0; i < nv; i++) begin
            do_reset();
            clear_imem();
            for (int k = 0; k < 6; k++) imem[k] = vecs[i].prog[k];
            fetch_lat = i % 3;
            run_prog($sformatf("v%0d", i), 200);
            check($sformatf("v%0d_done_cnt", i), done_cnt, 1);
            check($sformatf("v%0d_fetches", i), fetch_cnt, 32'(vecs[i].nf));
            check($sformatf("v%0d_busy", i), busy, 0);
            read_reg(int'(vecs[i].ridx), r);
            check($sformatf("v%0d_reg", i), r, vecs[i].exp);
        end
        fetch_lat = 1;

        // Wraparound of arithmetic and signed compare at the sign boundary
        do_reset();
        clear_imem();
        imem[0] = ldi(1, 1);
        for (int k = 1; k <= 31; k++) imem[k] = r3(OP_ADD, 1, 1, 1);
        imem[32] = ldi(2, -1);
        imem[33] = r3(OP_ADD, 2, 1, 2);
        imem[34] = ldi(4, 1);
        imem[35] = r3(OP_ADD, 3, 2, 4);
        imem[36] = r3(OP_LT, 5, 3, 4);
        imem[37] = hlt();
        run_prog("ovf", 600);
        check("ovf_fetches", fetch_cnt, 38);
        read_reg(2, r); check("ovf_max", r, 32'h7FFF_FFFF);
        read_reg(3, r); check("ovf_wrap", r, 32'h8000_0000);
        read_reg(5, r); check("ovf_lt", r, 32'd1);

        // Store with st_ready held off five cycles, then with st_ready already high
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            clear_imem();
            imem[0] = ldi(1, 'h40);
            imem[1] = ldi(2, 'h123);
            imem[2] = enc(OP_ST, 1, 2, 0, 0);
            imem[3] = hlt();
            st_delay = (pass == 0) ? 5 : 0;
            st_valid_cycles = 0;
            st_accepts = 0;
            exp_q.push_back({32'h40, 32'h123});
            run_prog($sformatf("st%0d", pass), 200);
            check($sformatf("st%0d_valid_cycles", pass), st_valid_cycles, (pass == 0) ? 6 : 1);
            check($sformatf("st%0d_accepts", pass), st_accepts, 1);
            check($sformatf("st%0d_q_empty", pass), 32'(exp_q.size()), 0);
            check($sformatf("st%0d_fetches", pass), fetch_cnt, 4);
            read_reg(1, r); check($sformatf("st%0d_rd_kept", pass), r, 32'h40);
        end
        st_delay = 0;

        // Illegal opcode at PC 3, then restart from 0
        do_reset();
        clear_imem();
        imem[2] = ldi(3, 7);
        imem[3] = enc(31, 3, 0, 0, 0);
        run_prog("flt", 200);
        check("flt_fault", fault, 1);
        check("flt_busy", busy, 0);
        check("flt_if_addr", 32'(if_addr), 3);
        check("flt_done_cnt", done_cnt, 0);
        read_reg(3, r); check("flt_no_write", r, 32'd7);
        imem[2] = 32'd0;
        imem[3] = hlt();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("flt_clear", fault, 0);
        check("flt_refetch_req", if_req, 1);
        check("flt_refetch_addr", 32'(if_addr), 0);
        fetch_cnt = 0;
        done_cnt = 0;
        wait_end("flt_restart", 200);
        repeat (2) @(negedge clk);
        check("flt_restart_done", done_cnt, 1);
        read_reg(3, r); check("flt_regs_kept", r, 32'd7);

        // PC wraps from 4095 to 0 without faulting
        do_reset();
        clear_imem();
        imem[0]    = br(OP_CJT, 7, 2);
        imem[1]    = br(OP_JMP, 0, 4095);
        imem[4095] = ldi(7, 3);
        imem[2]    = hlt();
        run_prog("wrap", 200);
        check("wrap_fetches", fetch_cnt, 5);
        check("wrap_done_cnt", done_cnt, 1);
        check("wrap_fault", fault, 0);
        check("wrap_if_addr", 32'(if_addr), 2);
        read_reg(7, r); check("wrap_reg", r, 32'd3);

        // Reset asserted while a store is pending
        do_reset();
        clear_imem();
        imem[0] = ldi(1, 5);
        imem[1] = enc(OP_ST, 1, 1, 0, 0);
        imem[2] = hlt();
        st_delay = 1000;
        exp_q.push_back({32'd5, 32'd5});
        pulse_start();
        for (int n = 0; n < 50 && !st_valid; n++) @(negedge clk);
        check("rs_st_valid", st_valid, 1);
        repeat (2) @(negedge clk);
        st_accepts = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rs_st_valid_drop", st_valid, 0);
        check("rs_busy", busy, 0);
        check("rs_st_addr", st_addr, 0);
        check("rs_st_data", st_data, 0);
        read_reg(1, r); check("rs_regs", r, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rs_no_accept", st_accepts, 0);
        check("rs_idle_valid", st_valid, 0);
        check("rs_idle_state", 32'(dbg_state), 0);
        st_delay = 0;

        // Reset asserted during a fetch that never returns
        do_reset();
        fetch_stall = 1'b1;
        pulse_start();
        repeat (4) @(negedge clk);
        check("rf_if_req_held", if_req, 1);
        check("rf_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rf_if_req_drop", if_req, 0);
        check("rf_busy_drop", busy, 0);
        check("rf_if_addr", 32'(if_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rf_idle", 32'(dbg_state), 0);
        check("rf_no_req", if_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
